// File: rtl/fast_iter_seq_controller.sv
// Fast-loop sequencer: drives the MUL -> MEAN -> SUB datapath phases, then loops
// through CHECK until the convergence checker agrees or the iteration limit is hit.
module fast_iter_seq_controller #(
   parameter int N_MUL    = 5,
   parameter int MUL_LAT  = 4,
   parameter int MEAN_LEN = 128,
   parameter int CNT_W    = 8,
   parameter int MAX_ITER = 16,
   parameter int ITER_W   = 5
) (
   input  logic              clk_fast,
   input  logic              go_fast,
   input  logic              start,
   input  logic              hold,
   input  logic              conv_valid,
   input  logic              conv_ok,
   output logic              en_b,
   output logic [N_MUL-1:0]  en_mul,
   output logic              en_mean,
   output logic              en_sub,
   output logic              fast_busy,
   output logic              done,
   output logic              converged,
   output logic [ITER_W-1:0] iter_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
      S_MEAN,
      S_SUB,
      S_CHECK,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0]  MUL_LAST  = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0]  MEAN_LAST = CNT_W'(MEAN_LEN - 1);
   localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ITER_W-1:0] iter_q, iter_d;
   logic              conv_q, conv_d;

   always_ff @(posedge clk_fast) begin
      if (!go_fast) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         iter_q  <= '0;
         conv_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         iter_q  <= iter_d;
         conv_q  <= conv_d;
      end
   end

   // A held cycle leaves every register untouched, so held cycles never count as phase cycles.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      iter_d  = iter_q;
      conv_d  = conv_q;
      if (!hold) begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d = S_MUL;
                  cnt_d   = '0;
                  iter_d  = ITER_W'(1);
                  conv_d  = 1'b0;
               end
            end
            S_MUL: begin
               if (cnt_q == MUL_LAST) begin
                  state_d = S_MEAN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_MEAN: begin
               if (cnt_q == MEAN_LAST) begin
                  state_d = S_SUB;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_SUB: begin
               state_d = S_CHECK;
            end
            S_CHECK: begin
               if (conv_valid) begin
                  if (conv_ok) begin
                     state_d = S_DONE;
                     conv_d  = 1'b1;
                  end else if (iter_q == ITER_LAST) begin
                     state_d = S_DONE;
                     conv_d  = 1'b0;
                  end else begin
                     state_d = S_MUL;
                     cnt_d   = '0;
                     iter_d  = iter_q + ITER_W'(1);
                  end
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Enables accumulate phase by phase; hold gates the enables but not busy/done.
   always_comb begin
      en_b      = 1'b0;
      en_mul    = '0;
      en_mean   = 1'b0;
      en_sub    = 1'b0;
      fast_busy = 1'b0;
      done      = 1'b0;
      case (state_q)
         S_MUL: begin
            en_b      = 1'b1;
            en_mul    = '1;
            fast_busy = 1'b1;
         end
         S_MEAN: begin
            en_b      = 1'b1;
            en_mul    = '1;
            en_mean   = 1'b1;
            fast_busy = 1'b1;
         end
         S_SUB: begin
            en_b      = 1'b1;
            en_mul    = '1;
            en_mean   = 1'b1;
            en_sub    = 1'b1;
            fast_busy = 1'b1;
         end
         S_CHECK: begin
            en_b      = 1'b1;
            fast_busy = 1'b1;
         end
         S_DONE: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
      if (hold) begin
         en_b    = 1'b0;
         en_mul  = '0;
         en_mean = 1'b0;
         en_sub  = 1'b0;
      end
   end

   assign converged = conv_q;
   assign iter_cnt  = iter_q;

endmodule

// File: tb/tb_fast_iter_seq_controller.sv
// Self-checking bench: two controller instances (default timing with a 3-iteration
// limit, and a minimal 1/1 timing with 8 multiplier stages) against a phase-count model.
module tb_fast_iter_seq_controller;

   localparam int ML_A = 4;
   localparam int MN_A = 128;
   localparam int NM_A = 5;
   localparam int MI_A = 3;
   localparam int ML_B = 1;
   localparam int MN_B = 1;
   localparam int NM_B = 8;
   localparam int MI_B = 16;

   logic       clk = 1'b0;
   logic       go_fast = 1'b0;
   logic       start = 1'b0;
   logic       hold = 1'b0;
   logic       conv_valid = 1'b0;
   logic       conv_ok = 1'b0;

   logic       en_b_a, en_mean_a, en_sub_a, busy_a, done_a, conv_a;
   logic [4:0] en_mul_a;
   logic [4:0] iter_a;
   logic       en_b_b, en_mean_b, en_sub_b, busy_b, done_b, conv_b;
   logic [7:0] en_mul_b;
   logic [4:0] iter_b;

   int total = 0;
   int bad = 0;

   typedef struct {
      bit busy;
      bit dn;
      bit conv;
      int k;
      int iter;
   } model_t;

   model_t mA = '{0, 0, 0, 0, 0};
   model_t mB = '{0, 0, 0, 0, 0};

   fast_iter_seq_controller #(
      .N_MUL(NM_A), .MUL_LAT(ML_A), .MEAN_LEN(MN_A), .CNT_W(8), .MAX_ITER(MI_A), .ITER_W(5)
   ) dutA (
      .clk_fast(clk), .go_fast(go_fast), .start(start), .hold(hold),
      .conv_valid(conv_valid), .conv_ok(conv_ok),
      .en_b(en_b_a), .en_mul(en_mul_a), .en_mean(en_mean_a), .en_sub(en_sub_a),
      .fast_busy(busy_a), .done(done_a), .converged(conv_a), .iter_cnt(iter_a)
   );

   fast_iter_seq_controller #(
      .N_MUL(NM_B), .MUL_LAT(ML_B), .MEAN_LEN(MN_B), .CNT_W(8), .MAX_ITER(MI_B), .ITER_W(5)
   ) dutB (
      .clk_fast(clk), .go_fast(go_fast), .start(start), .hold(hold),
      .conv_valid(conv_valid), .conv_ok(conv_ok),
      .en_b(en_b_b), .en_mul(en_mul_b), .en_mean(en_mean_b), .en_sub(en_sub_b),
      .fast_busy(busy_b), .done(done_b), .converged(conv_b), .iter_cnt(iter_b)
   );

   always #5 clk = ~clk;

   // k counts active cycles inside the current iteration: MUL, then MEAN, then one SUB, then CHECK.
   function automatic model_t model_next(model_t m, int ml, int mn, int mi,
                                         logic r, logic s, logic h, logic cv, logic co);
      model_t n;
      n = m;
      if (!r) begin
         n.busy = 0; n.dn = 0; n.conv = 0; n.k = 0; n.iter = 0;
      end else if (h) begin
         n = m;
      end else if (m.dn) begin
         n.dn = 0;
      end else if (!m.busy) begin
         if (s) begin
            n.busy = 1; n.k = 0; n.iter = 1; n.conv = 0;
         end
      end else if (m.k < ml + mn + 1) begin
         n.k = m.k + 1;
      end else if (cv) begin
         if (co) begin
            n.busy = 0; n.dn = 1; n.conv = 1;
         end else if (m.iter >= mi) begin
            n.busy = 0; n.dn = 1; n.conv = 0;
         end else begin
            n.k = 0; n.iter = m.iter + 1;
         end
      end
      return n;
   endfunction

   function automatic bit in_check(model_t m, int ml, int mn);
      return m.busy && (m.k == ml + mn + 1);
   endfunction

   function automatic logic [18:0] exp_vec(model_t m, int ml, int mn, int nm, logic h);
      logic       act;
      logic [7:0] mul;
      act = m.busy && !h;
      mul = '0;
      if (act && m.k <= ml + mn)
         for (int j = 0; j < nm; j++) mul[j] = 1'b1;
      return {act, mul, act && m.k >= ml && m.k <= ml + mn, act && m.k == ml + mn,
              m.busy, m.dn, m.conv, 5'(m.iter)};
   endfunction

   function automatic logic [18:0] act_a();
      return {en_b_a, 3'b000, en_mul_a, en_mean_a, en_sub_a, busy_a, done_a, conv_a, iter_a};
   endfunction

   function automatic logic [18:0] act_b();
      return {en_b_b, en_mul_b, en_mean_b, en_sub_b, busy_b, done_b, conv_b, iter_b};
   endfunction

   task automatic applyStimulus(input logic r, input logic s, input logic h,
                                input logic cv, input logic co);
      @(negedge clk);
      go_fast = r; start = s; hold = h; conv_valid = cv; conv_ok = co;
      @(posedge clk);
      mA = model_next(mA, ML_A, MN_A, MI_A, r, s, h, cv, co);
      mB = model_next(mB, ML_B, MN_B, MI_B, r, s, h, cv, co);
      #1;
   endtask

   task automatic test_reset();
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 1, 1);
      total++;
      if (act_a() !== exp_vec(mA, ML_A, MN_A, NM_A, 0)) begin
         bad++; $display("[TB] FAIL reset_a got=%h want=%h", act_a(), exp_vec(mA, ML_A, MN_A, NM_A, 0));
      end
      total++;
      if (act_b() !== exp_vec(mB, ML_B, MN_B, NM_B, 0)) begin
         bad++; $display("[TB] FAIL reset_b got=%h want=%h", act_b(), exp_vec(mB, ML_B, MN_B, NM_B, 0));
      end
   endtask

   task automatic test_single_pass();
      int busyN = 0, subN = 0, doneN = 0, chkAt = -1;
      logic cv;
      applyStimulus(0, 0, 0, 0, 0);
      for (int i = 0; i < 400; i++) begin
         cv = in_check(mA, ML_A, MN_A);
         applyStimulus(1, i == 0, 0, cv, 1);
         total++;
         if (act_a() !== exp_vec(mA, ML_A, MN_A, NM_A, 0)) begin
            bad++; $display("[TB] FAIL single_pass cyc=%0d got=%h want=%h", i, act_a(), exp_vec(mA, ML_A, MN_A, NM_A, 0));
         end
         if (busy_a) busyN++;
         if (en_sub_a) subN++;
         if (done_a) doneN++;
         if (chkAt < 0 && busy_a && en_b_a && en_mul_a == '0) chkAt = i;
         if (doneN > 0 && !done_a) break;
      end
      total++;
      if (chkAt != 133) begin bad++; $display("[TB] FAIL single_check_at got=%0d want=133", chkAt); end
      total++;
      if (busyN != 134) begin bad++; $display("[TB] FAIL single_busy_cycles got=%0d want=134", busyN); end
      total++;
      if (subN != 1) begin bad++; $display("[TB] FAIL single_sub_cycles got=%0d want=1", subN); end
      total++;
      if (doneN != 1) begin bad++; $display("[TB] FAIL single_done_pulses got=%0d want=1", doneN); end
      total++;
      if ({conv_a, iter_a} !== {1'b1, 5'd1}) begin
         bad++; $display("[TB] FAIL single_result got=%b/%0d want=1/1", conv_a, iter_a);
      end
   endtask

   task automatic test_iter_limit();
      int meanN = 0, doneN = 0;
      logic cv;
      applyStimulus(0, 0, 0, 0, 0);
      for (int i = 0; i < 1000; i++) begin
         cv = in_check(mA, ML_A, MN_A);
         applyStimulus(1, i == 0, 0, cv, 0);
         total++;
         if (act_a() !== exp_vec(mA, ML_A, MN_A, NM_A, 0)) begin
            bad++; $display("[TB] FAIL iter_limit cyc=%0d got=%h want=%h", i, act_a(), exp_vec(mA, ML_A, MN_A, NM_A, 0));
         end
         if (en_mean_a) meanN++;
         if (done_a) doneN++;
         if (doneN > 0 && !done_a) break;
      end
      total++;
      if (meanN != 3 * 129) begin bad++; $display("[TB] FAIL limit_mean_cycles got=%0d want=387", meanN); end
      total++;
      if (doneN != 1) begin bad++; $display("[TB] FAIL limit_done_pulses got=%0d want=1", doneN); end
      total++;
      if ({conv_a, iter_a} !== {1'b0, 5'd3}) begin
         bad++; $display("[TB] FAIL limit_result got=%b/%0d want=0/3", conv_a, iter_a);
      end
   endtask

   task automatic test_hold_mean();
      int holdLeft = 0, heldBad = 0, meanN = 0, chkAt = -1;
      bit started = 0;
      logic h, cv;
      applyStimulus(0, 0, 0, 0, 0);
      for (int i = 0; i < 400; i++) begin
         if (!started && mA.busy && mA.k == ML_A + 50) begin
            started = 1; holdLeft = 10;
         end
         h = (holdLeft > 0);
         if (h) holdLeft--;
         cv = in_check(mA, ML_A, MN_A) && !h;
         applyStimulus(1, i == 0, h, cv, 1);
         total++;
         if (act_a() !== exp_vec(mA, ML_A, MN_A, NM_A, h)) begin
            bad++; $display("[TB] FAIL hold_mean cyc=%0d got=%h want=%h", i, act_a(), exp_vec(mA, ML_A, MN_A, NM_A, h));
         end
         if (h && (en_b_a || en_mul_a != '0 || en_mean_a || en_sub_a || !busy_a)) heldBad++;
         if (en_mean_a) meanN++;
         if (chkAt < 0 && !h && busy_a && en_b_a && en_mul_a == '0) chkAt = i;
         if (done_a) break;
      end
      total++;
      if (heldBad != 0) begin bad++; $display("[TB] FAIL hold_outputs got=%0d want=0", heldBad); end
      total++;
      if (meanN != 129) begin bad++; $display("[TB] FAIL hold_mean_cycles got=%0d want=129", meanN); end
      total++;
      if (chkAt != 143) begin bad++; $display("[TB] FAIL hold_check_at got=%0d want=143", chkAt); end
   endtask

   task automatic test_reset_mid();
      int doneN = 0, chkAt = -1;
      logic cv;
      applyStimulus(0, 0, 0, 0, 0);
      for (int i = 0; i < 100; i++) begin
         applyStimulus(1, i == 0, 0, 0, 0);
         if (mA.k == ML_A + 60) break;
      end
      applyStimulus(0, 0, 0, 0, 0);
      total++;
      if (act_a() !== 19'd0) begin bad++; $display("[TB] FAIL mid_reset_outputs got=%h want=0", act_a()); end
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 0, 0, 0, 0);
         if (done_a) doneN++;
      end
      total++;
      if (doneN != 0) begin bad++; $display("[TB] FAIL mid_reset_done got=%0d want=0", doneN); end
      for (int i = 0; i < 400; i++) begin
         cv = in_check(mA, ML_A, MN_A);
         applyStimulus(1, i == 0, 0, cv, 1);
         total++;
         if (act_a() !== exp_vec(mA, ML_A, MN_A, NM_A, 0)) begin
            bad++; $display("[TB] FAIL mid_reset_rerun cyc=%0d got=%h want=%h", i, act_a(), exp_vec(mA, ML_A, MN_A, NM_A, 0));
         end
         if (chkAt < 0 && busy_a && en_b_a && en_mul_a == '0) chkAt = i;
         if (done_a) doneN++;
         if (doneN > 0 && !done_a) break;
      end
      total++;
      if (chkAt != 133 || doneN != 1) begin
         bad++; $display("[TB] FAIL mid_reset_rerun_timing got=%0d/%0d want=133/1", chkAt, doneN);
      end
   endtask

   task automatic test_ignored_start();
      int chkAt = -1, doneN = 0;
      bit chkSeen = 0, inChk;
      logic st, cv;
      applyStimulus(0, 0, 0, 0, 0);
      for (int i = 0; i < 400; i++) begin
         inChk = in_check(mA, ML_A, MN_A);
         cv = inChk && chkSeen;
         st = (i == 0) || (i == 2) || (i == 70) || inChk;
         if (inChk) chkSeen = 1;
         applyStimulus(1, st, 0, cv, 1);
         total++;
         if (act_a() !== exp_vec(mA, ML_A, MN_A, NM_A, 0)) begin
            bad++; $display("[TB] FAIL ignored_start cyc=%0d got=%h want=%h", i, act_a(), exp_vec(mA, ML_A, MN_A, NM_A, 0));
         end
         if (chkAt < 0 && busy_a && en_b_a && en_mul_a == '0) chkAt = i;
         if (done_a) doneN++;
         if (doneN > 0 && !done_a) break;
      end
      total++;
      if (chkAt != 133 || iter_a !== 5'd1) begin
         bad++; $display("[TB] FAIL ignored_start_timing got=%0d/%0d want=133/1", chkAt, iter_a);
      end
      applyStimulus(1, 1, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 0, 0, 0, 0);
         total++;
         if (act_a() !== exp_vec(mA, ML_A, MN_A, NM_A, 0)) begin
            bad++; $display("[TB] FAIL blocked_start cyc=%0d got=%h want=%h", i, act_a(), exp_vec(mA, ML_A, MN_A, NM_A, 0));
         end
      end
      total++;
      if ({busy_a, conv_a, iter_a} !== {1'b0, 1'b1, 5'd1}) begin
         bad++; $display("[TB] FAIL blocked_start_state got=%b/%b/%0d want=0/1/1", busy_a, conv_a, iter_a);
      end
   endtask

   task automatic test_param_sweep();
      int chkAt = -1, subN = 0, mulN = 0;
      logic cv;
      applyStimulus(0, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) begin
         cv = in_check(mB, ML_B, MN_B);
         applyStimulus(1, i == 0, 0, cv, 1);
         total++;
         if (act_b() !== exp_vec(mB, ML_B, MN_B, NM_B, 0)) begin
            bad++; $display("[TB] FAIL sweep cyc=%0d got=%h want=%h", i, act_b(), exp_vec(mB, ML_B, MN_B, NM_B, 0));
         end
         if (en_mul_b == 8'hFF) mulN++;
         if (en_sub_b) subN++;
         if (chkAt < 0 && busy_b && en_b_b && en_mul_b == '0) chkAt = i;
         if (done_b) break;
      end
      total++;
      if (chkAt != 3) begin bad++; $display("[TB] FAIL sweep_check_at got=%0d want=3", chkAt); end
      total++;
      if (mulN != 3 || subN != 1) begin
         bad++; $display("[TB] FAIL sweep_enables got=%0d/%0d want=3/1", mulN, subN);
      end
      total++;
      if (conv_b !== 1'b1) begin bad++; $display("[TB] FAIL sweep_converged got=%b want=1", conv_b); end
   endtask

   task automatic test_random();
      logic r, s, h, cv, co;
      applyStimulus(0, 0, 0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         r  = ($urandom_range(0, 399) != 0);
         s  = ($urandom_range(0, 7) == 0);
         h  = ($urandom_range(0, 5) == 0);
         cv = ($urandom_range(0, 2) == 0);
         co = ($urandom_range(0, 3) == 0);
         applyStimulus(r, s, h, cv, co);
         total++;
         if (act_a() !== exp_vec(mA, ML_A, MN_A, NM_A, h)) begin
            bad++; $display("[TB] FAIL random_a cyc=%0d got=%h want=%h", i, act_a(), exp_vec(mA, ML_A, MN_A, NM_A, h));
         end
         total++;
         if (act_b() !== exp_vec(mB, ML_B, MN_B, NM_B, h)) begin
            bad++; $display("[TB] FAIL random_b cyc=%0d got=%h want=%h", i, act_b(), exp_vec(mB, ML_B, MN_B, NM_B, h));
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_pass();
      test_iter_limit();
      test_hold_mean();
      test_reset_mid();
      test_ignored_start();
      test_param_sweep();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fast_iter_seq_controller.md
Name: fast_iter_seq_controller

Overview:
- Parametrised successor to the one-unit FastICA fast-loop controller.
- Sequences the MUL → MEAN → SUB datapath phases with configurable multiplier-stage count, pipeline latency and mean window length.
- Adds start/done handshake, a datapath hold (stall), and multi-iteration looping until the convergence checker reports converged or an iteration limit is hit.
- Sits between the top-level FastICA FSM and the b-decision, multiplier, mean and subtract units.

Parameters:
N_MUL, 5, number of multiplier stages; width of en_mul.
MUL_LAT, 4, cycles spent in MUL (pipeline fill); must be >= 1.
MEAN_LEN, 128, cycles spent in MEAN (samples accumulated); must be >= 1.
CNT_W, 8, phase counter width; must satisfy 2^CNT_W > max(MUL_LAT, MEAN_LEN).
MAX_ITER, 16, maximum iterations per start; must be >= 1.
ITER_W, 5, iteration counter width; must satisfy 2^ITER_W > MAX_ITER.

Ports:
clk_fast  in  1  single clock; all state changes on its rising edge.
go_fast  in  1  reset: synchronous, active-low.
start  in  1  single-cycle request to begin; sampled only in IDLE.
hold  in  1  stall: freezes state and counters, forces all en_* low.
conv_valid  in  1  convergence-check result valid.
conv_ok  in  1  convergence result; sampled only when conv_valid=1 in CHECK.
en_b  out  1  b-decision enable.
en_mul  out  N_MUL  per-stage multiplier enables.
en_mean  out  1  mean accumulator enable.
en_sub  out  1  subtract-unit enable.
fast_busy  out  1  high from MUL through CHECK.
done  out  1  one-cycle pulse at completion.
converged  out  1  sticky result flag: converged=1, limit reached=0.
iter_cnt  out  ITER_W  number of iterations started since the last start.

Behaviour:
Reset:
- go_fast=0 at a rising edge: state=IDLE, phase counter=0, iter_cnt=0, converged=0.
- Applies from any state, including mid-MEAN; no partial completion; done is not pulsed.

Output decode (combinational from state; all en_* forced to 0 while hold=1):
- IDLE: all enables 0, fast_busy=0.
- MUL: en_b=1, en_mul=all ones, fast_busy=1.
- MEAN: as MUL, plus en_mean=1.
- SUB: as MEAN, plus en_sub=1.
- CHECK: en_b=1, all other enables 0, fast_busy=1.
- DONE: all enables 0, fast_busy=0, done=1.

Transitions:
- IDLE → MUL when start=1.
  - On this edge: iter_cnt=1, converged=0, phase counter=0.
  - start is ignored in every other state.
- MUL: the counter increments each non-held cycle. Go to MEAN when counter==MUL_LAT-1, which gives exactly MUL_LAT active cycles.
- MEAN: the counter restarts at 0. Go to SUB when counter==MEAN_LEN-1, which gives exactly MEAN_LEN active cycles.
- SUB → CHECK after exactly 1 cycle.
- CHECK: waits indefinitely for conv_valid=1.
  - conv_ok=1 → DONE with converged=1.
  - conv_ok=0 and iter_cnt==MAX_ITER → DONE with converged=0.
  - Otherwise → MUL with iter_cnt+1 and counter=0.
- DONE → IDLE after 1 cycle. converged and iter_cnt hold their values until the next start.

Hold:
- While hold=1, state, counter and iter_cnt are frozen; conv_valid is ignored; fast_busy keeps its state value.
- Hold in IDLE also blocks start.
- Hold does not extend phase active-cycle counts; held cycles are not counted.

Simultaneous events:
- go_fast=0 has priority over everything.
- hold=1 has priority over start and conv_valid.

Latency (defaults, no hold): start edge → first CHECK cycle = 4 + 128 + 1 = 133 cycles.

Test Plan:
1. Reset then single converged pass:
   - Stimulus: go_fast=0 for 2 cycles, then start pulse; conv_valid=1, conv_ok=1 on the first CHECK cycle.
   - Response: MUL 4 cycles, MEAN 128 cycles, SUB 1 cycle (en_sub high exactly 1 cycle); done pulses the cycle after CHECK; converged=1, iter_cnt=1; fast_busy high for 134 cycles.
2. Iteration limit:
   - Stimulus: MAX_ITER=3; answer conv_ok=0 every CHECK.
   - Response: three full MUL/MEAN/SUB passes; done with converged=0, iter_cnt=3; en_mean high for 3×129 cycles total.
3. Hold mid-MEAN:
   - Stimulus: assert hold for 10 cycles at MEAN counter=50.
   - Response: all en_* are 0 during the hold, the counter stays at 50, and MEAN still totals 128 active cycles; CHECK is reached 143 cycles after start.
4. Reset mid-operation:
   - Stimulus: go_fast=0 for 1 cycle during MEAN.
   - Response: next cycle is IDLE with all outputs 0, iter_cnt=0, no done pulse; a subsequent start runs a full 133-cycle pass.
5. Ignored and blocked start:
   - Stimulus: start pulses during MUL, MEAN and CHECK; then start together with hold=1 in IDLE.
   - Response: no restart and no counter disturbance in either case; state stays IDLE.
6. Parameter sweep:
   - Stimulus: N_MUL=8, MUL_LAT=1, MEAN_LEN=1.
   - Response: en_mul=8'hFF; MUL 1 cycle, MEAN 1 cycle, SUB 1 cycle; CHECK entered 3 cycles after start.
